// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs into the clk domain.
// Latency: 2 clk cycles from d_i sample to q_o.
// Backpressure: none; free-running every cycle.
// Ports: clk, rst (sync, active-high), d_i (async input), q_o (synchronized).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
    end else begin
      sync1 <= d_i;
      sync2 <= sync1;
    end
  end

  assign q_o = sync2;

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw async level: 2-flop sync then a counter-qualified FSM.
// Latency: signal_o follows a clean step STABLE_CYCLES+1 edges after first sample.
// Backpressure: none; input is a level, output toggles at most once per qualification.
// Ports: clk, rst (sync, active-high), noisy_i (raw level), signal_o (debounced),
//        busy_o (qualification in progress), glitch_cnt_o (aborted transitions,
//        only when DEBOUNCE_GLITCH_CNT_EN is defined).
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    noisy_i,
  output logic                    signal_o,
  output logic                    busy_o
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single required cycle the first differing sample already qualifies.
  localparam bit ONE_SHOT = (STABLE_CYCLES == 1);
  localparam deb_state_t RST_STATE = INIT_LEVEL ? IDLE_HIGH : IDLE_LOW;

  if (STABLE_CYCLES < 1) begin : g_bad_param
    $error("input_debouncer: STABLE_CYCLES must be >= 1");
  end

  logic       s;
  deb_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       sig_q, sig_d;
  logic       busy_q, busy_d;
  logic       glitch_ev;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (INIT_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (noisy_i),
    .q_o (s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    glitch_ev = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          if (ONE_SHOT) begin
            sig_d   = 1'b1;
            state_d = IDLE_HIGH;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          cnt_d     = '0;
          state_d   = IDLE_LOW;
          glitch_ev = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          sig_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          if (ONE_SHOT) begin
            sig_d   = 1'b0;
            state_d = IDLE_LOW;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        if (s) begin
          cnt_d     = '0;
          state_d   = IDLE_HIGH;
          glitch_ev = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          sig_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RST_STATE;
      end
    endcase
    // Registered from next state so busy_o lines up exactly with WAIT_* residency.
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      sig_q   <= INIT_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
    end
  end

  assign signal_o = sig_q;
  assign busy_o   = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (glitch_ev && (glitch_q != GLITCH_CNT_MAX)) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign glitch_cnt_o = glitch_q;
`else
  logic unused_glitch_ev;
  assign unused_glitch_ev = glitch_ev;
`endif

endmodule
